// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding,
// the ALU opcodes that steer control flow, and the default halt machine code.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEMWAIT,
        ST_DONE
    } seq_state_t;

    localparam logic [3:0] ALU_BLT = 4'b0110;
    localparam logic [3:0] ALU_BEQ = 4'b0111;
    localparam logic [3:0] ALU_JMP = 4'b1100;
    localparam logic [3:0] ALU_BRC = 4'b1101;

    localparam logic [8:0] DEFAULT_HALT_CODE = 9'h1FF;

endpackage

// File: rtl/jump_lut.sv
// 32-entry jump-target ROM indexed by the decoder's jump pointer; purely
// combinational, no latency, no flow control. Entry i sits at LUT_INIT[i*PC_W +: PC_W].
module jump_lut #(
    parameter int                PC_W     = 10,
    parameter logic [32*PC_W-1:0] LUT_INIT = '0
) (
    input  logic [4:0]      Jptr,
    output logic [PC_W-1:0] target
);

    assign target = LUT_INIT[32'(Jptr)*PC_W +: PC_W];

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: 2 cycles per instruction, 3 for loads (MEMWAIT).
// No backpressure; Start is honoured only in IDLE or DONE, ignored mid-run.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int                 PC_W      = 10,
    parameter logic [8:0]         HALT_CODE = DEFAULT_HALT_CODE,
    parameter logic [32*PC_W-1:0] LUT_INIT  = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [8:0]      MachCode,
    input  logic [3:0]      Aluop,
    input  logic [4:0]      Jptr,
    input  logic            WenR,
    input  logic            WenD,
    input  logic            Ldr,
    input  logic            AluCmp,
    output logic [PC_W-1:0] Pc,
    output logic            InstrEn,
    output logic            Jen,
    output logic            RegWrEn,
    output logic            MemWrEn,
    output logic            Done
);

    seq_state_t      state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic            jen_q, jen_nxt;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] pc_inc;
    logic            halt;

    jump_lut #(
        .PC_W     (PC_W),
        .LUT_INIT (LUT_INIT)
    ) u_jump_lut (
        .Jptr   (Jptr),
        .target (jump_target)
    );

    // Natural wrap at 2^PC_W is intended.
    assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign halt   = (MachCode == HALT_CODE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            pc_q  <= '0;
            jen_q <= 1'b0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            jen_q <= jen_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        jen_nxt   = jen_q;
        InstrEn   = 1'b0;
        Done      = 1'b0;
        RegWrEn   = 1'b0;
        MemWrEn   = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                Done = (state == ST_DONE);
                if (Start) begin
                    pc_nxt    = '0;
                    jen_nxt   = 1'b0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                InstrEn   = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (halt) begin
                    state_nxt = ST_DONE;
                end else begin
                    // Loads defer the register write to MEMWAIT, when read data is back.
                    RegWrEn = WenR & ~Ldr;
                    MemWrEn = WenD;
                    case (Aluop)
                        ALU_BLT, ALU_BEQ: begin
                            jen_nxt = AluCmp;
                            pc_nxt  = pc_inc;
                        end
                        ALU_JMP: pc_nxt = jump_target;
                        ALU_BRC: begin
                            if (jen_q) begin
                                pc_nxt  = jump_target;
                                jen_nxt = 1'b0;
                            end else begin
                                pc_nxt  = pc_inc;
                            end
                        end
                        default: pc_nxt = pc_inc;
                    endcase
                    state_nxt = Ldr ? ST_MEMWAIT : ST_FETCH;
                end
            end
            ST_MEMWAIT: begin
                RegWrEn   = WenR;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign Pc  = pc_q;
    assign Jen = jen_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: a behavioural ROM/decoder table feeds the sequencer and each
// observation is compared against hand-derived values.
module tb_instr_sequencer;

    localparam int PC_W = 10;
    localparam logic [32*PC_W-1:0] LUT =
        (320'(4)) | (320'(1023) << 10) | (320'(20) << 30);

    typedef struct packed {
        logic [8:0] mach;
        logic [3:0] op;
        logic [4:0] jptr;
        logic       wenr;
        logic       wend;
        logic       ldr;
        logic       cmp;
    } instr_t;

    logic            Clk, Reset, Start;
    logic [8:0]      MachCode;
    logic [3:0]      Aluop;
    logic [4:0]      Jptr;
    logic            WenR, WenD, Ldr, AluCmp;
    logic [PC_W-1:0] Pc;
    logic            InstrEn, Jen, RegWrEn, MemWrEn, Done;

    instr_t prog [1024];
    instr_t rom_q = '0;
    int     total = 0;
    int     bad   = 0;

    instr_sequencer #(
        .PC_W      (PC_W),
        .HALT_CODE (9'h1FF),
        .LUT_INIT  (LUT)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .MachCode (MachCode),
        .Aluop    (Aluop),
        .Jptr     (Jptr),
        .WenR     (WenR),
        .WenD     (WenD),
        .Ldr      (Ldr),
        .AluCmp   (AluCmp),
        .Pc       (Pc),
        .InstrEn  (InstrEn),
        .Jen      (Jen),
        .RegWrEn  (RegWrEn),
        .MemWrEn  (MemWrEn),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous ROM + decoder: fields are valid the cycle after the fetch.
    always @(posedge Clk) if (InstrEn) rom_q <= prog[Pc];
    assign MachCode = rom_q.mach;
    assign Aluop    = rom_q.op;
    assign Jptr     = rom_q.jptr;
    assign WenR     = rom_q.wenr;
    assign WenD     = rom_q.wend;
    assign Ldr      = rom_q.ldr;
    assign AluCmp   = rom_q.cmp;

    function automatic instr_t mk(input logic [8:0] mach, input logic [3:0] op,
                                  input logic [4:0] jptr, input logic wenr,
                                  input logic wend, input logic ldr, input logic cmp);
        mk = '{mach: mach, op: op, jptr: jptr, wenr: wenr, wend: wend, ldr: ldr, cmp: cmp};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = '0;
    endtask

    task automatic seek_fetch(input logic [PC_W-1:0] pc, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (InstrEn && Pc == pc) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        clear_prog();
        prog[0]  = mk(9'h011, 4'b0001, 5'd0, 1, 0, 0, 0);
        prog[1]  = mk(9'h012, 4'b0010, 5'd0, 1, 0, 0, 0);
        prog[5]  = mk(9'h0A5, 4'b0000, 5'd0, 1, 0, 1, 0);
        prog[7]  = mk(9'h017, 4'b0111, 5'd0, 0, 0, 0, 1);
        prog[8]  = mk(9'h018, 4'b1101, 5'd3, 0, 0, 0, 0);
        prog[9]  = mk(9'h1FF, 4'b0001, 5'd0, 1, 1, 0, 0);
        prog[20] = mk(9'h1FF, 4'b0001, 5'd0, 1, 1, 0, 0);

        step(); step();
        check("rst_pc", 32'(Pc), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_instren", 32'(InstrEn), 0);
        check("rst_regwr", 32'(RegWrEn), 0);
        check("rst_memwr", 32'(MemWrEn), 0);
        check("rst_jen", 32'(Jen), 0);

        // Two ALU ops from PC 0
        Reset = 1'b0; Start = 1'b1;
        step(); Start = 1'b0;
        check("fetch0_pc", 32'(Pc), 0);
        check("fetch0_en", 32'(InstrEn), 1);
        step();
        check("exec0_regwr", 32'(RegWrEn), 1);
        check("exec0_instren", 32'(InstrEn), 0);
        step();
        check("fetch1_pc", 32'(Pc), 1);
        check("fetch1_regwr", 32'(RegWrEn), 0);
        step();
        check("exec1_regwr", 32'(RegWrEn), 1);
        step();
        check("fetch2_pc", 32'(Pc), 2);

        // Load at PC 5
        seek_fetch(5, "seek_load");
        step();
        check("load_exec_regwr", 32'(RegWrEn), 0);
        step();
        check("load_memwait_regwr", 32'(RegWrEn), 1);
        check("load_memwait_instren", 32'(InstrEn), 0);
        step();
        check("after_load_pc", 32'(Pc), 6);
        check("after_load_instren", 32'(InstrEn), 1);

        // beq taken then brc_jmp to lut[3]=20
        seek_fetch(8, "seek_brc_taken");
        step();
        check("brc_exec_jen", 32'(Jen), 1);
        step();
        check("brc_taken_pc", 32'(Pc), 20);
        check("brc_taken_jen", 32'(Jen), 0);
        step(); step();
        check("halt20_done", 32'(Done), 1);

        // Same with compare false
        prog[7].cmp = 1'b0;
        Start = 1'b1;
        step(); Start = 1'b0;
        check("restart_pc", 32'(Pc), 0);
        check("restart_done", 32'(Done), 0);
        seek_fetch(8, "seek_brc_not");
        step();
        check("brc_not_jen", 32'(Jen), 0);
        step();
        check("brc_not_pc", 32'(Pc), 9);
        step();
        check("halt_regwr", 32'(RegWrEn), 0);
        check("halt_memwr", 32'(MemWrEn), 0);
        step();
        check("halt9_done", 32'(Done), 1);
        check("halt9_pc", 32'(Pc), 9);

        // Store then halt, Start held during the run
        clear_prog();
        prog[2] = mk(9'h0B2, 4'b0000, 5'd0, 0, 1, 0, 0);
        prog[3] = mk(9'h1FF, 4'b0000, 5'd0, 1, 1, 0, 0);
        Start = 1'b1;
        step();
        check("st_fetch0", 32'(Pc), 0);
        step();
        check("st_exec0_memwr", 32'(MemWrEn), 0);
        step();
        check("st_fetch1_held_start", 32'(Pc), 1);
        step(); step();
        check("st_fetch2_held_start", 32'(Pc), 2);
        step();
        check("st_exec2_memwr", 32'(MemWrEn), 1);
        Start = 1'b0;
        step();
        check("st_fetch3_pc", 32'(Pc), 3);
        check("st_fetch3_memwr", 32'(MemWrEn), 0);
        step();
        check("st_halt_memwr", 32'(MemWrEn), 0);
        check("st_halt_done", 32'(Done), 0);
        step();
        check("st_done_rise", 32'(Done), 1);
        check("st_done_pc", 32'(Pc), 3);
        step();
        check("st_done_hold", 32'(Done), 1);

        // Wrap at 1023 then jump-to-self at PC 4
        clear_prog();
        prog[0]    = mk(9'h0C1, 4'b1100, 5'd1, 0, 0, 0, 0);
        prog[1023] = mk(9'h005, 4'b0001, 5'd0, 1, 0, 0, 0);
        Start = 1'b1;
        step(); Start = 1'b0;
        check("st_restart_pc", 32'(Pc), 0);
        check("st_restart_done", 32'(Done), 0);
        seek_fetch(1023, "seek_1023");
        prog[0] = mk(9'h0C0, 4'b1100, 5'd0, 0, 0, 0, 0);
        prog[4] = mk(9'h0C0, 4'b1100, 5'd0, 0, 0, 0, 0);
        step();
        check("exec1023_regwr", 32'(RegWrEn), 1);
        step();
        check("wrap_pc", 32'(Pc), 0);
        step(); step();
        check("jump_pc", 32'(Pc), 4);
        for (int i = 0; i < 3; i++) begin
            step(); step();
            check("self_loop_pc", 32'(Pc), 4);
            check("self_loop_en", 32'(InstrEn), 1);
        end

        // Reset during MEMWAIT
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        clear_prog();
        prog[0] = mk(9'h0D0, 4'b0110, 5'd0, 0, 0, 0, 1);
        prog[1] = mk(9'h0D1, 4'b0000, 5'd0, 1, 0, 1, 0);
        Start = 1'b1;
        step(); Start = 1'b0;
        step(); step();
        check("rm_fetch1_pc", 32'(Pc), 1);
        step();
        check("rm_exec_regwr", 32'(RegWrEn), 0);
        step();
        check("rm_memwait_regwr", 32'(RegWrEn), 1);
        check("rm_memwait_jen", 32'(Jen), 1);
        Reset = 1'b1;
        #1;
        check("rm_reset_regwr", 32'(RegWrEn), 0);
        check("rm_reset_pc", 32'(Pc), 0);
        check("rm_reset_jen", 32'(Jen), 0);
        check("rm_reset_done", 32'(Done), 0);
        check("rm_reset_instren", 32'(InstrEn), 0);
        step();
        Reset = 1'b0;
        step(); step();
        check("rm_idle_instren", 32'(InstrEn), 0);
        check("rm_idle_done", 32'(Done), 0);
        Start = 1'b1;
        step(); Start = 1'b0;
        check("rm_start_instren", 32'(InstrEn), 1);
        check("rm_start_pc", 32'(Pc), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
